// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel colour type for the display path.
package vga_pkg;

    // 640x480 @ 60 Hz timing, pixel counts for horizontal, line counts for vertical
    localparam int unsigned H_VISIBLE_DEFAULT = 640;
    localparam int unsigned H_FP_DEFAULT      = 16;
    localparam int unsigned H_SYNC_DEFAULT    = 96;
    localparam int unsigned H_BP_DEFAULT      = 48;
    localparam int unsigned V_VISIBLE_DEFAULT = 480;
    localparam int unsigned V_FP_DEFAULT      = 10;
    localparam int unsigned V_SYNC_DEFAULT    = 2;
    localparam int unsigned V_BP_DEFAULT      = 33;
    localparam int unsigned CLK_DIV_DEFAULT   = 2;

    localparam int unsigned H_TOTAL_DEFAULT =
        H_VISIBLE_DEFAULT + H_FP_DEFAULT + H_SYNC_DEFAULT + H_BP_DEFAULT;
    localparam int unsigned V_TOTAL_DEFAULT =
        V_VISIBLE_DEFAULT + V_FP_DEFAULT + V_SYNC_DEFAULT + V_BP_DEFAULT;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_sync_decode.sv
// Combinational decode of scan counters into visible / hsync / vsync flags.
module vga_sync_decode
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEFAULT,
    parameter int unsigned H_FP      = H_FP_DEFAULT,
    parameter int unsigned H_SYNC    = H_SYNC_DEFAULT,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEFAULT,
    parameter int unsigned V_FP      = V_FP_DEFAULT,
    parameter int unsigned V_SYNC    = V_SYNC_DEFAULT
) (
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    output logic       visible,
    output logic       hsync_act,
    output logic       vsync_act
);

    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Region decode: sync windows are half-open [begin, end)
    always_comb begin
        visible   = (hc < H_VIS_END) && (vc < V_VIS_END);
        hsync_act = (hc >= H_SYNC_BEG) && (hc < H_SYNC_END);
        vsync_act = (vc >= V_SYNC_BEG) && (vc < V_SYNC_END);
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator and registered VGA DAC output stage.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEFAULT,
    parameter int unsigned H_FP      = H_FP_DEFAULT,
    parameter int unsigned H_SYNC    = H_SYNC_DEFAULT,
    parameter int unsigned H_BP      = H_BP_DEFAULT,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEFAULT,
    parameter int unsigned V_FP      = V_FP_DEFAULT,
    parameter int unsigned V_SYNC    = V_SYNC_DEFAULT,
    parameter int unsigned V_BP      = V_BP_DEFAULT,
    parameter int unsigned CLK_DIV   = CLK_DIV_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_en,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_VIS_LAST = 10'(V_VISIBLE - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       hc;
    logic [9:0]       vc;
    logic             visible;
    logic             hsync_act;
    logic             vsync_act;
    rgb_t             pix_rgb;

    vga_sync_decode #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC)
    ) u_decode (
        .hc        (hc),
        .vc        (vc),
        .visible   (visible),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act)
    );

    assign DrawX      = hc;
    assign DrawY      = vc;
    assign VGA_SYNC_N = 1'b0;

    // Pixel strobe and frame strobe decoded from registered state only, so
    // both drop to 0 the moment reset clears the divider
    always_comb begin
        pix_en      = (div_cnt == DIV_LAST);
        frame_start = pix_en && (hc == H_LAST) && (vc == V_VIS_LAST);
        div_nxt     = pix_en ? '0 : div_cnt + 1'b1;
        pix_rgb     = visible ? '{r: Red, g: Green, b: Blue} : '0;
    end

    // Clock divider; VGA_CLK follows the next divider value so it is low for
    // the first half of each pixel and rises after the outputs have settled
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            VGA_CLK <= (div_nxt >= DIV_HALF);
        end
    end

    // Horizontal/vertical scan counters, both wrapping in the same step at frame end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Output stage: captures the decode of the pre-increment coordinate so
    // syncs, blank and colour stay mutually aligned one pixel behind DrawX/DrawY
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= ~hsync_act;
            VGA_VS      <= ~vsync_act;
            VGA_BLANK_N <= visible;
            VGA_R       <= pix_rgb.r;
            VGA_G       <= pix_rgb.g;
            VGA_B       <= pix_rgb.b;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen using a reduced raster so whole frames fit.
module tb_vga_scan_gen;

    localparam int unsigned HV  = 120;
    localparam int unsigned HF  = 4;
    localparam int unsigned HSW = 8;
    localparam int unsigned HB  = 6;
    localparam int unsigned VV  = 60;
    localparam int unsigned VF  = 3;
    localparam int unsigned VSW = 2;
    localparam int unsigned VB  = 4;
    localparam int unsigned CD  = 2;
    localparam int unsigned HT  = HV + HF + HSW + HB;
    localparam int unsigned VT  = VV + VF + VSW + VB;
    localparam int unsigned FRAME_CLK = HT * VT * CD;
    localparam int unsigned NVEC = 16;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Red, Green, Blue;
    logic [9:0] DrawX, DrawY;
    logic       pix_en, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic [7:0] salt = 8'h00;

    int unsigned t;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       fs;
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       sn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } snap_t;

    typedef struct {
        int unsigned t;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        pe;
        logic        fs;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bl;
    } vec_t;

    vec_t        vt [NVEC];
    int unsigned vidx = 0;

    vga_scan_gen #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .CLK_DIV   (CD)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    always #5 Clk = ~Clk;

    // Stand-in for color_mapper: a pure function of the coordinates
    always_comb begin
        Red   = DrawX[7:0];
        Green = DrawY[7:0];
        Blue  = DrawX[7:0] ^ DrawY[7:0] ^ salt;
    end

    function automatic snap_t actual();
        snap_t s;
        s = '{x: DrawX, y: DrawY, pe: pix_en, fs: frame_start, vclk: VGA_CLK,
              hs: VGA_HS, vs: VGA_VS, bl: VGA_BLANK_N, sn: VGA_SYNC_N,
              r: VGA_R, g: VGA_G, b: VGA_B};
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s = '0;
        s.hs = 1'b1;
        s.vs = 1'b1;
        return s;
    endfunction

    // Reference: tt clocks after reset release -> pixel index and phase
    function automatic snap_t model(input int unsigned tt);
        snap_t       m;
        int unsigned p, ph, q, ox, oy;
        logic        vis;
        p  = tt / CD;
        ph = tt % CD;
        m  = reset_snap();
        m.x    = 10'(p % HT);
        m.y    = 10'((p / HT) % VT);
        m.pe   = (ph == CD - 1);
        m.fs   = m.pe && (p % HT == HT - 1) && ((p / HT) % VT == VV - 1);
        m.vclk = (ph >= CD / 2);
        if (p != 0) begin
            q   = p - 1;
            ox  = q % HT;
            oy  = (q / HT) % VT;
            vis = (ox < HV) && (oy < VV);
            m.hs = !((ox >= HV + HF) && (ox < HV + HF + HSW));
            m.vs = !((oy >= VV + VF) && (oy < VV + VF + VSW));
            m.bl = vis;
            m.r  = vis ? 8'(ox) : 8'h00;
            m.g  = vis ? 8'(oy) : 8'h00;
            m.b  = vis ? (8'(ox) ^ 8'(oy) ^ salt) : 8'h00;
        end
        return m;
    endfunction

    task automatic cmp_snap(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    // Timing measurement state
    snap_t       prev;
    logic        prev_ok;
    longint      t_line, t_hs_fall, t_vs_fall, t_fs;
    logic        line_ok, hs_fall_ok, vs_fall_ok, fs_ok;
    int unsigned fs_count;

    task automatic meas_reset();
        prev_ok    = 1'b0;
        line_ok    = 1'b0;
        hs_fall_ok = 1'b0;
        vs_fall_ok = 1'b0;
        fs_ok      = 1'b0;
    endtask

    task automatic observe(input snap_t s);
        if (s.x == 0 && (!prev_ok || prev.x != 0)) begin
            t_line  = t;
            line_ok = 1'b1;
        end
        if (prev_ok) begin
            if (prev.hs && !s.hs) begin
                if (line_ok) cmp_int("hs_start", t - t_line, (HV + HF) * CD + CD);
                if (hs_fall_ok) cmp_int("line_period", t - t_hs_fall, HT * CD);
                t_hs_fall  = t;
                hs_fall_ok = 1'b1;
            end
            if (!prev.hs && s.hs && hs_fall_ok) cmp_int("hs_width", t - t_hs_fall, HSW * CD);
            if (prev.vs && !s.vs) begin
                cmp_int("vs_line", s.y, VV + VF);
                t_vs_fall  = t;
                vs_fall_ok = 1'b1;
            end
            if (!prev.vs && s.vs && vs_fall_ok) cmp_int("vs_width", t - t_vs_fall, VSW * HT * CD);
            if (prev.fs) cmp_int("fs_after", {s.fs, s.x, s.y}, {1'b0, 10'd0, 10'(VV)});
            if (prev.x == HT - 1 && prev.y == VT - 1 && s.x != prev.x)
                cmp_int("wrap_corner", {s.x, s.y}, 20'd0);
        end
        if (s.fs) begin
            fs_count++;
            cmp_int("fs_pos", {s.x, s.y}, {10'(HT - 1), 10'(VV - 1)});
            if (fs_ok) cmp_int("fs_period", t - t_fs, FRAME_CLK);
            t_fs  = t;
            fs_ok = 1'b1;
        end
        if (s.vclk && s.x == 101 && s.y == 50)
            cmp_int("colour_100_50", {s.r, s.g, s.bl}, {8'd100, 8'd50, 1'b1});
        if (s.vclk && s.x == HV + HF + 3)
            cmp_int("blank_rgb", {s.r, s.bl, s.hs}, {8'd0, 1'b0, 1'b0});
        prev    = s;
        prev_ok = 1'b1;
    endtask

    // Runs up to n clocks checking every sample; optionally stops (before
    // advancing) when the scan reaches (sx,sy)
    task automatic step_run(input int unsigned n, input logic stop_en,
                            input logic [9:0] sx, input logic [9:0] sy,
                            output logic hit);
        snap_t s;
        hit = 1'b0;
        for (int unsigned i = 0; i < n && !hit; i++) begin
            s = actual();
            if (stop_en && s.x == sx && s.y == sy) begin
                hit = 1'b1;
            end else begin
                cmp_snap("model", s, model(t));
                if (vidx < NVEC && vt[vidx].t == t) begin
                    cmp_int("vector", {s.x, s.y, s.pe, s.fs, s.vclk, s.hs, s.vs, s.bl},
                            {vt[vidx].x, vt[vidx].y, vt[vidx].pe, vt[vidx].fs,
                             vt[vidx].vclk, vt[vidx].hs, vt[vidx].vs, vt[vidx].bl});
                    vidx++;
                end
                observe(s);
                @(posedge Clk);
                @(negedge Clk);
                t++;
            end
        end
    endtask

    // Asserts reset mid-cycle, checks outputs respond before the next edge,
    // then releases on a falling edge and restarts the model timebase
    task automatic mid_reset(input string name);
        #2 Reset_n = 1'b0;
        #1 cmp_snap(name, actual(), reset_snap());
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        cmp_snap("reset_hold", actual(), reset_snap());
        salt    = 8'($urandom);
        Reset_n = 1'b1;
        t       = 0;
        meas_reset();
    endtask

    initial begin
        logic hit;
        //        t      x    y  pe fs vclk hs vs bl
        vt[0]  = '{0,     0,   0, 0, 0, 0,  1, 1, 0};
        vt[1]  = '{1,     0,   0, 1, 0, 1,  1, 1, 0};
        vt[2]  = '{2,     1,   0, 0, 0, 0,  1, 1, 1};
        vt[3]  = '{248,   124, 0, 0, 0, 0,  1, 1, 0};
        vt[4]  = '{250,   125, 0, 0, 0, 0,  0, 1, 0};
        vt[5]  = '{264,   132, 0, 0, 0, 0,  0, 1, 0};
        vt[6]  = '{266,   133, 0, 0, 0, 0,  1, 1, 0};
        vt[7]  = '{276,   0,   1, 0, 0, 0,  1, 1, 0};
        vt[8]  = '{278,   1,   1, 0, 0, 0,  1, 1, 1};
        vt[9]  = '{16559, 137, 59, 1, 1, 1, 1, 1, 0};
        vt[10] = '{16560, 0,   60, 0, 0, 0, 1, 1, 0};
        vt[11] = '{17388, 0,   63, 0, 0, 0, 1, 1, 0};
        vt[12] = '{17390, 1,   63, 0, 0, 0, 1, 0, 0};
        vt[13] = '{19043, 137, 68, 1, 0, 1, 1, 1, 0};
        vt[14] = '{19044, 0,   0,  0, 0, 0, 1, 1, 0};
        vt[15] = '{19046, 1,   0,  0, 0, 0, 1, 1, 1};

        salt     = 8'($urandom);
        fs_count = 0;
        t        = 0;
        meas_reset();

        // Power-on reset held for 5 clocks
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        cmp_snap("reset_state", actual(), reset_snap());
        Reset_n = 1'b1;

        // Two full frames plus margin against the model and the vector table
        step_run(2 * FRAME_CLK + 20, 1'b0, 10'd0, 10'd0, hit);
        cmp_int("fs_count", fs_count, 2);
        cmp_int("vectors_used", vidx, NVEC);

        // Asynchronous reset at a fixed mid-frame coordinate
        step_run(2 * FRAME_CLK, 1'b1, 10'd100, 10'd30, hit);
        cmp_int("reach_100_30", hit, 1);
        mid_reset("async_reset_fixed");
        fs_count = 0;
        step_run(600, 1'b0, 10'd0, 10'd0, hit);
        cmp_int("no_partial_fs", fs_count, 0);

        // Asynchronous reset at a random point, then resume
        step_run($urandom_range(300, 3000), 1'b0, 10'd0, 10'd0, hit);
        mid_reset("async_reset_random");
        step_run(400, 1'b0, 10'd0, 10'd0, hit);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
